// File: rtl/serial_add_sub.sv
// Bit-serial add/subtract, one result bit per clock LSB first; valid op completes WIDTH+2 cycles after start.
// No backpressure: start is only accepted in IDLE/DONE and is dropped while busy; the result is held until the next accepted start.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             add_en,
  input  logic             sub_en,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] data_out,
  output logic             carry_out,
  output logic             out_en
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             op_add;
  logic             op_sub;
  logic             cy;
  logic [CW-1:0]    cnt;

  logic sum_bit;
  logic carry_nxt;
  logic last_step;

  always_comb begin
    sum_bit   = a_sr[0] ^ b_sr[0] ^ cy;
    carry_nxt = (a_sr[0] & b_sr[0]) | (cy & (a_sr[0] ^ b_sr[0]));
    last_step = (cnt == CW'(WIDTH - 1));
  end

  // The result register doubles as data_out: sum bits enter at the MSB and
  // after WIDTH steps the bit computed first has reached bit 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sr      <= '0;
      b_sr      <= '0;
      op_add    <= 1'b0;
      op_sub    <= 1'b0;
      cy        <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= '0;
      carry_out <= 1'b0;
      out_en    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr   <= A;
            b_sr   <= B;
            op_add <= add_en;
            op_sub <= sub_en;
            cy     <= carry_in;
            out_en <= 1'b0;
            busy   <= 1'b1;
            state  <= LOAD;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          if (op_add ^ op_sub) begin
            // Subtract as A + ~B + ~borrow; the final carry then means "no borrow".
            if (op_sub) begin
              b_sr <= ~b_sr;
              cy   <= ~cy;
            end
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            data_out  <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        SHIFT: begin
          data_out <= {sum_bit, data_out[WIDTH-1:1]};
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          cy       <= carry_nxt;
          cnt      <= cnt + CW'(1);
          if (last_step) begin
            carry_out <= carry_nxt;
            busy      <= 1'b0;
            done      <= 1'b1;
            out_en    <= 1'b1;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed plus randomized checks of serial_add_sub (WIDTH=8) against an arithmetic reference model.
module tb_serial_add_sub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       add_en;
  logic       sub_en;
  logic       carry_in;
  logic       busy;
  logic       done;
  logic [7:0] data_out;
  logic       carry_out;
  logic       out_en;

  int tests = 0;
  int fails = 0;

  serial_add_sub #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .add_en(add_en), .sub_en(sub_en), .carry_in(carry_in),
    .busy(busy), .done(done), .data_out(data_out),
    .carry_out(carry_out), .out_en(out_en)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: {carry_out, data_out} from plain integer arithmetic.
  function automatic logic [8:0] golden(input logic [7:0] a, input logic [7:0] b,
                                        input bit sub, input bit ci);
    int r;
    logic [8:0] g;
    if (!sub) begin
      r = int'(a) + int'(b) + int'(ci);
      g = r[8:0];
    end else begin
      r = int'(a) - int'(b) - int'(ci);
      g = {(int'(a) >= int'(b) + int'(ci)), r[7:0]};
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE, scramble the inputs afterwards, and check
  // latency, busy length, result, flags and the hold in the following IDLE cycle.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input bit ad, input bit sb, input bit ci);
    int cyc;
    int lat;
    int busy_cnt;
    bit valid;
    logic [8:0] exp;
    cyc = 0;
    lat = -1;
    busy_cnt = 0;
    valid = ad ^ sb;
    exp = valid ? golden(a, b, sb, ci) : 9'd0;
    A = a; B = b; add_en = ad; sub_en = sb; carry_in = ci; start = 1'b1;
    while (cyc < 40 && lat < 0) begin
      tick();
      cyc++;
      if (cyc == 1) begin
        start = 1'b0;
        chk({tag, ".oe_drop"}, out_en, 0);
        A = 8'($urandom); B = 8'($urandom);
        add_en = 1'($urandom); sub_en = 1'($urandom); carry_in = 1'($urandom);
      end
      if (busy) busy_cnt++;
      if (done) lat = cyc;
    end
    chk({tag, ".latency"}, lat, valid ? 10 : 2);
    chk({tag, ".busy_cycles"}, busy_cnt, valid ? 9 : 1);
    chk({tag, ".data"}, data_out, exp[7:0]);
    chk({tag, ".carry"}, carry_out, exp[8]);
    chk({tag, ".out_en"}, out_en, valid);
    tick();
    chk({tag, ".done_pulse"}, done, 0);
    chk({tag, ".hold_data"}, data_out, exp[7:0]);
    chk({tag, ".hold_oe"}, out_en, valid);
  endtask

  initial begin
    int cyc;
    int dones;
    int lat;
    int lat2;
    logic [7:0] d1;
    logic [7:0] d2;
    logic c1;
    logic c2;
    logic [8:0] e;
    int kind;
    bit ad;
    bit sb;

    rst_n = 1'b0; start = 1'b0; A = 8'd0; B = 8'd0;
    add_en = 1'b0; sub_en = 1'b0; carry_in = 1'b0;
    repeat (3) tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.out_en", out_en, 0);
    chk("rst.data", data_out, 0);
    chk("rst.carry", carry_out, 0);
    rst_n = 1'b1;
    tick();

    run_op("add200_100", 8'd200, 8'd100, 1, 0, 0);
    chk("add200_100.lit_data", data_out, 44);
    chk("add200_100.lit_carry", carry_out, 1);
    run_op("sub5_7", 8'd5, 8'd7, 0, 1, 0);
    chk("sub5_7.lit_data", data_out, 254);
    chk("sub5_7.lit_carry", carry_out, 0);
    run_op("sub7_5", 8'd7, 8'd5, 0, 1, 0);
    chk("sub7_5.lit_data", data_out, 2);
    run_op("sub7_5_b", 8'd7, 8'd5, 0, 1, 1);
    chk("sub7_5_b.lit_data", data_out, 1);
    chk("sub7_5_b.lit_carry", carry_out, 1);
    run_op("inv_both", 8'd33, 8'd44, 1, 1, 1);
    run_op("inv_none", 8'd12, 8'd250, 0, 0, 0);
    run_op("add_max", 8'd255, 8'd255, 1, 0, 1);
    run_op("sub_eq_b", 8'd0, 8'd0, 0, 1, 1);

    // Start pulsed mid-SHIFT must be ignored.
    A = 8'd150; B = 8'd77; add_en = 1'b1; sub_en = 1'b0; carry_in = 1'b1; start = 1'b1;
    e = golden(8'd150, 8'd77, 0, 1);
    cyc = 0; dones = 0; lat = -1; d1 = 8'd0; c1 = 1'b0;
    while (cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (cyc == 4) begin
        A = 8'd3; B = 8'd9; add_en = 1'b0; sub_en = 1'b1; start = 1'b1;
      end
      if (cyc == 5) start = 1'b0;
      if (done) begin
        dones++;
        if (lat < 0) begin lat = cyc; d1 = data_out; c1 = carry_out; end
      end
    end
    chk("busy_start.dones", dones, 1);
    chk("busy_start.latency", lat, 10);
    chk("busy_start.data", d1, e[7:0]);
    chk("busy_start.carry", c1, e[8]);

    // Start held high through DONE: second op follows immediately.
    A = 8'd90; B = 8'd200; add_en = 1'b0; sub_en = 1'b1; carry_in = 1'b0; start = 1'b1;
    cyc = 0; lat = -1; lat2 = -1; d1 = 8'd0; c1 = 1'b0; d2 = 8'd0; c2 = 1'b0;
    while (cyc < 40 && lat2 < 0) begin
      tick();
      cyc++;
      if (done && lat < 0) begin
        lat = cyc; d1 = data_out; c1 = carry_out;
        A = 8'd100; B = 8'd101; add_en = 1'b1; sub_en = 1'b0; carry_in = 1'b1;
      end else if (done) begin
        lat2 = cyc; d2 = data_out; c2 = carry_out;
      end
    end
    start = 1'b0;
    e = golden(8'd90, 8'd200, 1, 0);
    chk("b2b.first_latency", lat, 10);
    chk("b2b.first_data", d1, e[7:0]);
    chk("b2b.first_carry", c1, e[8]);
    e = golden(8'd100, 8'd101, 0, 1);
    chk("b2b.spacing", lat2 - lat, 10);
    chk("b2b.second_data", d2, e[7:0]);
    chk("b2b.second_carry", c2, e[8]);
    tick();

    // Reset in the middle of an add.
    A = 8'd240; B = 8'd31; add_en = 1'b1; sub_en = 1'b0; carry_in = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.busy", busy, 0);
    chk("midrst.done", done, 0);
    chk("midrst.out_en", out_en, 0);
    chk("midrst.data", data_out, 0);
    chk("midrst.carry", carry_out, 0);
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done || busy) dones++;
    end
    chk("midrst.no_activity", dones, 0);
    run_op("after_rst", 8'd240, 8'd31, 1, 0, 1);

    // Randomized operations, mostly valid, some invalid.
    for (int i = 0; i < 400; i++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        ad = 1'($urandom);
        sb = ad;
      end else begin
        ad = (kind < 5);
        sb = !ad;
      end
      run_op($sformatf("rnd%0d", i), 8'($urandom), 8'($urandom), ad, sb, 1'($urandom));
      if (($urandom & 3) == 0) repeat (int'($urandom_range(1, 3))) tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial, multi-cycle counterpart to the combinational `adder_sub` datapath. It accepts a pair of operands and an operation through a start/done handshake, then computes one result bit per clock, LSB first. It presents the same result and flag outputs as `adder_sub` (`data_out`, `carry_out`, `out_en`), so the existing A+B/A−B sweep benches can check it against the combinational unit. It sits in the arithmetic path where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: request a new operation. Sampled only in IDLE or DONE.
- `A` in WIDTH: first operand, captured on an accepted `start`.
- `B` in WIDTH: second operand, captured on an accepted `start`.
- `add_en` in 1: operation select, captured with the operands.
- `sub_en` in 1: operation select, captured with the operands.
- `carry_in` in 1: carry for add, borrow for sub; captured with the operands.
- `busy` out 1: high in LOAD and SHIFT.
- `done` out 1: one-cycle pulse when a result is presented.
- `data_out` out WIDTH: result; held stable from `done` until the next accepted `start`.
- `carry_out` out 1: for add, carry out; for sub, 1 = no borrow. Held like `data_out`.
- `out_en` out 1: high when the held result is valid.

## Operation
- States are IDLE, LOAD, SHIFT and DONE.
- **IDLE:** `start`=1 captures `A`, `B`, `add_en`, `sub_en` and `carry_in`, then moves to LOAD.
- **LOAD, valid op** (exactly one of `add_en`/`sub_en`):
  - Add: operand B register = B; carry flop = `carry_in`.
  - Sub: operand B register = ~B; carry flop = ~`carry_in`.
  - Bit counter clears to 0; go to SHIFT.
- **LOAD, invalid op** (both or neither enable): result register and `carry_out` clear to 0; go to DONE with `out_en`=0.
- **SHIFT:** one full-adder step per cycle on the LSB of the A and B shift registers plus the carry flop.
  - The sum bit shifts into the MSB of the result register.
  - The operand registers shift right; the counter increments.
  - After exactly WIDTH steps, go to DONE.
- **Arithmetic:**
  - Add: {`carry_out`,`data_out`} = A + B + `carry_in`, mod 2^(WIDTH+1).
  - Sub: `data_out` = (A − B − `carry_in`) mod 2^WIDTH; `carry_out` = 1 exactly when A ≥ B + `carry_in`.
- **DONE:**
  - `done`=1 for this cycle only.
  - `out_en`=1 for a valid op, 0 for an invalid op.
  - With `start`=1: capture a new op and go to LOAD (back-to-back operation).
  - With `start`=0: go to IDLE.
- **Result hold:** `data_out`, `carry_out` and `out_en` hold their values in IDLE. `out_en` drops to 0 on the cycle after the next accepted `start`, and `data_out`/`carry_out` may change from then on.
- **Start while busy:** `start` in LOAD or SHIFT is ignored, not queued.
- Input changes outside an accepted-`start` edge have no effect.

## Timing
- **Reset** (`rst_n`=0 at a rising edge): state = IDLE, `busy`=0, `done`=0, `out_en`=0, `data_out`=0, `carry_out`=0; counter and operand registers = 0.
- Reset applies in any state, including mid-SHIFT. The in-flight operation is discarded and no `done` is produced.
- **Latency, valid op:** `start` sampled at edge 0.
  - LOAD in cycle 1.
  - SHIFT in cycles 2..WIDTH+1.
  - `done`=1 in cycle WIDTH+2 (cycle 10 for WIDTH=8).
- **Latency, invalid op:** `done`=1 in cycle 2.
- **Throughput:** back-to-back operation gives one result every WIDTH+2 cycles.
- **`busy`:** high from cycle 1 through the last SHIFT cycle; low in DONE and IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Add, WIDTH=8:** A=200, B=100, `add_en`=1, `carry_in`=0, `start` pulse → `done` 10 cycles later with `data_out`=44, `carry_out`=1, `out_en`=1; `busy` high for 9 cycles.
- **Subtract, borrow and no borrow:**
  - A=5, B=7, `sub_en`=1, `carry_in`=0 → `data_out`=254, `carry_out`=0.
  - Then A=7, B=5 → `data_out`=2, `carry_out`=1.
  - Then A=7, B=5, `carry_in`=1 → `data_out`=1, `carry_out`=1.
- **Invalid op:** `add_en`=`sub_en`=1, `start` → `done` at cycle 2 with `out_en`=0, `data_out`=0, `carry_out`=0.
- **Handshake edge cases:**
  - Pulse `start` with new operands during SHIFT → ignored; the first result is correct and exactly one `done` occurs.
  - Hold `start` high through DONE → second op accepted; its `done` arrives 10 cycles after the first.
- **Reset mid-operation:** assert `rst_n`=0 for 1 cycle at cycle 5 of an add → next cycle all outputs are 0 and state is IDLE; no `done` follows; a new op then completes normally.
- **Exhaustive sweep:** all 65,536 A/B pairs, both ops, `carry_in` 0/1 → {`carry_out`,`data_out`} matches the golden formula above on every `done`; zero mismatches reported.
